multicycle_controller: RTL and testbench

- Sequencing FSM that turns the existing MIPS datapath into a multi-cycle machine sharing one ALU and one unified memory port.
- Each cycle it decodes the current state (plus OP/FUNC/ZERO) into datapath control strobes.
- Counts retired instructions and raises a sticky trap on unsupported opcodes.

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath.
// The controller side is the master: it consumes instruction fields and drives strobes.
interface multicycle_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       OP;
   logic [5:0]       FUNC;
   logic             ZERO;
   logic             PC_EN;
   logic             I_OR_D;
   logic             MEM_WE;
   logic             IR_WE;
   logic             REG_WE;
   logic [1:0]       REG_DST;
   logic [1:0]       WB_SEL;
   logic [1:0]       SRC_A;
   logic [1:0]       SRC_B;
   logic             SIGN_EXT;
   logic [5:0]       ALU_OP;
   logic [1:0]       PC_SRC;
   logic             TRAP;
   logic [CNT_W-1:0] RETIRED;
   logic [3:0]       STATE;

   modport master (
      input  OP, FUNC, ZERO,
      output PC_EN, I_OR_D, MEM_WE, IR_WE, REG_WE, REG_DST, WB_SEL,
             SRC_A, SRC_B, SIGN_EXT, ALU_OP, PC_SRC, TRAP, RETIRED, STATE
   );

   modport slave (
      output OP, FUNC, ZERO,
      input  PC_EN, I_OR_D, MEM_WE, IR_WE, REG_WE, REG_DST, WB_SEL,
             SRC_A, SRC_B, SIGN_EXT, ALU_OP, PC_SRC, TRAP, RETIRED, STATE
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS sequencer: decodes state plus OP/FUNC/ZERO into datapath strobes,
// counts retired instructions and latches a sticky trap on unsupported encodings.
module multicycle_controller #(
   parameter int CNT_W  = 32,
   parameter int RA_REG = 31
) (
   input  logic                     CLK,
   input  logic                     RESET,
   multicycle_controller_if.master  bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_ALUWB = 4'd7,
      S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_JUMP   = 4'd10, S_JAL   = 4'd11,
      S_JR     = 4'd12, S_TRAP   = 4'd15
   } state_t;

   localparam logic [5:0] ALU_ADD = 6'h20;
   localparam logic [5:0] ALU_SUB = 6'h22;
   localparam logic [5:0] ALU_AND = 6'h24;
   localparam logic [5:0] ALU_OR  = 6'h25;
   localparam logic [5:0] ALU_SLT = 6'h2A;

   // The register index itself is applied in the datapath's write-index mux.
   if (RA_REG < 0 || RA_REG > 31) begin : g_bad_ra
      $error("RA_REG must be a 5-bit register index");
   end

   state_t           state_reg, state_next;
   logic             trap_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             retire;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg   <= S_FETCH;
         trap_reg    <= 1'b0;
         retired_reg <= '0;
      end else begin
         state_reg   <= state_next;
         trap_reg    <= trap_reg | (state_next == S_TRAP);
         retired_reg <= retired_reg + CNT_W'(retire);
      end
   end

   always_comb begin
      state_next   = state_reg;
      retire       = 1'b0;
      bus.PC_EN    = 1'b0;
      bus.I_OR_D   = 1'b0;
      bus.MEM_WE   = 1'b0;
      bus.IR_WE    = 1'b0;
      bus.REG_WE   = 1'b0;
      bus.REG_DST  = 2'd0;
      bus.WB_SEL   = 2'd0;
      bus.SRC_A    = 2'd0;
      bus.SRC_B    = 2'd0;
      bus.SIGN_EXT = 1'b0;
      bus.ALU_OP   = 6'h00;
      bus.PC_SRC   = 2'd0;
      case (state_reg)
         S_FETCH: begin
            bus.IR_WE  = 1'b1;
            bus.SRC_B  = 2'd1;
            bus.ALU_OP = ALU_ADD;
            bus.PC_EN  = 1'b1;
            state_next = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes the branch target while the opcode is dispatched.
            bus.SRC_B    = 2'd3;
            bus.SIGN_EXT = 1'b1;
            bus.ALU_OP   = ALU_ADD;
            case (bus.OP)
               6'h23, 6'h2B:              state_next = S_MEMADR;
               6'h04, 6'h05:              state_next = S_BRANCH;
               6'h08, 6'h0C, 6'h0D, 6'h0A: state_next = S_IEXEC;
               6'h02:                     state_next = S_JUMP;
               6'h03:                     state_next = S_JAL;
               6'h00: begin
                  if (bus.FUNC == 6'h08)
                     state_next = S_JR;
                  else if (bus.FUNC inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
                     state_next = S_REXEC;
                  else
                     state_next = S_TRAP;
               end
               default:                   state_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            bus.SRC_A    = 2'd1;
            bus.SRC_B    = 2'd2;
            bus.SIGN_EXT = 1'b1;
            bus.ALU_OP   = ALU_ADD;
            state_next   = (bus.OP == 6'h23) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.I_OR_D = 1'b1;
            state_next = S_MEMWB;
         end
         S_MEMWB: begin
            bus.REG_WE = 1'b1;
            bus.WB_SEL = 2'd1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            bus.I_OR_D = 1'b1;
            bus.MEM_WE = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_REXEC: begin
            bus.SRC_A  = (bus.FUNC == 6'h00 || bus.FUNC == 6'h02) ? 2'd2 : 2'd1;
            bus.ALU_OP = bus.FUNC;
            state_next = S_ALUWB;
         end
         S_IEXEC: begin
            bus.SRC_A    = 2'd1;
            bus.SRC_B    = 2'd2;
            bus.SIGN_EXT = !(bus.OP == 6'h0C || bus.OP == 6'h0D);
            case (bus.OP)
               6'h0C:   bus.ALU_OP = ALU_AND;
               6'h0D:   bus.ALU_OP = ALU_OR;
               6'h0A:   bus.ALU_OP = ALU_SLT;
               default: bus.ALU_OP = ALU_ADD;
            endcase
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            bus.REG_WE  = 1'b1;
            bus.REG_DST = (bus.OP == 6'h00) ? 2'd1 : 2'd0;
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_BRANCH: begin
            bus.SRC_A  = 2'd1;
            bus.ALU_OP = ALU_SUB;
            bus.PC_SRC = 2'd1;
            bus.PC_EN  = (bus.OP == 6'h04) ? bus.ZERO : !bus.ZERO;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            bus.PC_SRC = 2'd2;
            bus.PC_EN  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_JAL: begin
            // PC still holds PC+4 of the jal this cycle, so the link value is correct.
            bus.PC_SRC  = 2'd2;
            bus.PC_EN   = 1'b1;
            bus.REG_WE  = 1'b1;
            bus.REG_DST = 2'd2;
            bus.WB_SEL  = 2'd2;
            retire      = 1'b1;
            state_next  = S_FETCH;
         end
         S_JR: begin
            bus.PC_SRC = 2'd3;
            bus.PC_EN  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_TRAP;
      endcase
      // Reset presents the FETCH selects with every write strobe held off.
      if (RESET) begin
         bus.PC_EN    = 1'b0;
         bus.I_OR_D   = 1'b0;
         bus.MEM_WE   = 1'b0;
         bus.IR_WE    = 1'b0;
         bus.REG_WE   = 1'b0;
         bus.REG_DST  = 2'd0;
         bus.WB_SEL   = 2'd0;
         bus.SRC_A    = 2'd0;
         bus.SRC_B    = 2'd1;
         bus.SIGN_EXT = 1'b0;
         bus.ALU_OP   = ALU_ADD;
         bus.PC_SRC   = 2'd0;
      end
   end

   assign bus.TRAP    = trap_reg;
   assign bus.RETIRED = retired_reg;
   assign bus.STATE   = state_reg;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller against a
// per-instruction path/control reference model.
module tb_multicycle_controller;
   localparam int CNT_W = 5;

   logic clk;
   logic srst;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [CNT_W-1:0] exp_retired;
   logic             exp_trap;

   multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

   multicycle_controller #(.CNT_W(CNT_W), .RA_REG(31)) dut (
      .CLK   (clk),
      .RESET (srst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [21:0] pk(input bit pc_en, input bit i_or_d, input bit mem_we,
                                      input bit ir_we, input bit reg_we, input logic [1:0] reg_dst,
                                      input logic [1:0] wb_sel, input logic [1:0] src_a,
                                      input logic [1:0] src_b, input bit sign_ext,
                                      input logic [5:0] alu_op, input logic [1:0] pc_src);
      return {pc_en, i_or_d, mem_we, ir_we, reg_we, reg_dst, wb_sel, src_a, src_b,
              sign_ext, alu_op, pc_src};
   endfunction

   function automatic logic [21:0] obs_ctrl();
      return {bus.PC_EN, bus.I_OR_D, bus.MEM_WE, bus.IR_WE, bus.REG_WE, bus.REG_DST,
              bus.WB_SEL, bus.SRC_A, bus.SRC_B, bus.SIGN_EXT, bus.ALU_OP, bus.PC_SRC};
   endfunction

   function automatic logic [21:0] reset_ctrl();
      return pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 6'h20, 2'd0);
   endfunction

   // Expected control word for one step of an instruction.
   function automatic logic [21:0] exp_ctrl(input int st, input logic [5:0] op,
                                            input logic [5:0] func, input bit zero);
      logic [5:0] iop;
      case (op)
         6'h0C:   iop = 6'h24;
         6'h0D:   iop = 6'h25;
         6'h0A:   iop = 6'h2A;
         default: iop = 6'h20;
      endcase
      case (st)
         0:  return pk(1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 6'h20, 2'd0);
         1:  return pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd3, 1, 6'h20, 2'd0);
         2:  return pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd2, 1, 6'h20, 2'd0);
         3:  return pk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 6'h00, 2'd0);
         4:  return pk(0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd0, 2'd0, 0, 6'h00, 2'd0);
         5:  return pk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 6'h00, 2'd0);
         6:  return pk(0, 0, 0, 0, 0, 2'd0, 2'd0, (func == 6'h00 || func == 6'h02) ? 2'd2 : 2'd1,
                       2'd0, 0, func, 2'd0);
         7:  return pk(0, 0, 0, 0, 1, (op == 6'h00) ? 2'd1 : 2'd0, 2'd0, 2'd0, 2'd0, 0, 6'h00, 2'd0);
         8:  return pk((op == 6'h04) ? zero : !zero, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 0,
                       6'h22, 2'd1);
         9:  return pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd2, !(op == 6'h0C || op == 6'h0D),
                       iop, 2'd0);
         10: return pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 6'h00, 2'd2);
         11: return pk(1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 2'd0, 0, 6'h00, 2'd2);
         12: return pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 6'h00, 2'd3);
         default: return '0;
      endcase
   endfunction

   // State sequence of one instruction; a trap path ends with 10 cycles parked in TRAP.
   task automatic build_path(input logic [5:0] op, input logic [5:0] func, output int path[$]);
      path = {0, 1};
      case (op)
         6'h23: path = {path, 2, 3, 4};
         6'h2B: path = {path, 2, 5};
         6'h04, 6'h05: path = {path, 8};
         6'h08, 6'h0C, 6'h0D, 6'h0A: path = {path, 9, 7};
         6'h02: path = {path, 10};
         6'h03: path = {path, 11};
         6'h00: begin
            if (func == 6'h08) path = {path, 12};
            else if (func inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
               path = {path, 6, 7};
            else for (int i = 0; i < 10; i++) path.push_back(15);
         end
         default: for (int i = 0; i < 10; i++) path.push_back(15);
      endcase
   endtask

   // Entered and left at posedge+1. abort_at < 0 runs the instruction to completion.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input bit zero,
                            input int abort_at);
      int path[$];
      build_path(op, func, path);
      bus.OP   = op;
      bus.FUNC = func;
      bus.ZERO = zero;
      for (int k = 0; k < path.size(); k++) begin
         if (k == abort_at) begin
            srst = 1'b1;
            #1;
            check("abort_state", 64'(bus.STATE), 64'(path[k]));
            check("abort_ctrl", 64'(obs_ctrl()), 64'(reset_ctrl()));
            @(posedge clk); #1;
            srst        = 1'b0;
            exp_retired = '0;
            exp_trap    = 1'b0;
            check("post_abort_state", 64'(bus.STATE), 64'd0);
            check("post_abort_retired", 64'(bus.RETIRED), 64'(exp_retired));
            $display("[TB] op=%02h func=%02h zero=%0b aborted at step %0d", op, func, zero, k);
            return;
         end
         #1;
         check("state", 64'(bus.STATE), 64'(path[k]));
         check("ctrl", 64'(obs_ctrl()), 64'(exp_ctrl(path[k], op, func, zero)));
         check("retired", 64'(bus.RETIRED), 64'(exp_retired));
         check("trap", 64'(bus.TRAP), 64'(exp_trap));
         @(posedge clk); #1;
         if (k + 1 < path.size() && path[k + 1] == 15) exp_trap = 1'b1;
      end
      if (path[path.size() - 1] == 15) begin
         srst = 1'b1;
         #1;
         check("trap_reset_ctrl", 64'(obs_ctrl()), 64'(reset_ctrl()));
         @(posedge clk); #1;
         srst        = 1'b0;
         exp_retired = '0;
         exp_trap    = 1'b0;
         check("trap_cleared", 64'(bus.TRAP), 64'd0);
      end else begin
         exp_retired = exp_retired + 1'b1;
      end
      $display("[TB] op=%02h func=%02h zero=%0b cycles=%0d retired=%0d",
               op, func, zero, path.size(), exp_retired);
   endtask

   initial begin
      logic [5:0] ops[11]   = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                                6'h0A, 6'h02, 6'h03};
      logic [5:0] bad_ops[6] = '{6'h3F, 6'h01, 6'h06, 6'h10, 6'h20, 6'h2F};
      logic [5:0] rfuncs[8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
      srst        = 1'b1;
      bus.OP      = 6'h00;
      bus.FUNC    = 6'h20;
      bus.ZERO    = 1'b0;
      exp_retired = '0;
      exp_trap    = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         check("rst_state", 64'(bus.STATE), 64'd0);
         check("rst_retired", 64'(bus.RETIRED), 64'd0);
         check("rst_trap", 64'(bus.TRAP), 64'd0);
         check("rst_ctrl", 64'(obs_ctrl()), 64'(reset_ctrl()));
      end
      srst = 1'b0;

      run_instr(6'h23, 6'h00, 1'b0, -1);
      run_instr(6'h04, 6'h00, 1'b1, -1);
      run_instr(6'h05, 6'h00, 1'b1, -1);
      run_instr(6'h00, 6'h00, 1'b0, -1);
      run_instr(6'h0D, 6'h00, 1'b0, -1);
      run_instr(6'h03, 6'h00, 1'b0, -1);
      run_instr(6'h00, 6'h08, 1'b0, -1);

      for (int n = 0; n < 160; n++) begin
         logic [5:0] op, func;
         int         abort_at;
         op   = ($urandom_range(0, 11) == 0) ? bad_ops[$urandom_range(0, 5)]
                                            : ops[$urandom_range(0, 10)];
         func = ($urandom_range(0, 6) == 0) ? 6'($urandom_range(0, 63))
                                          : rfuncs[$urandom_range(0, 7)];
         abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : -1;
         run_instr(op, func, 1'($urandom_range(0, 1)), abort_at);
      end

      run_instr(6'h3F, 6'h00, 1'b0, -1);
      run_instr(6'h23, 6'h00, 1'b0, 3);
      run_instr(6'h2B, 6'h00, 1'b0, 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
